// File: rtl/bus_master_arbiter.sv
// rtl/bus_master_arbiter.sv - round-robin arbiter sharing the CPU bus among secondary masters
module bus_master_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int MAX_HOLD    = 64
) (
  input  logic                     clk,
  input  logic                     clk_ce,
  input  logic                     reset,
  input  logic [NUM_MASTERS-1:0]   m_request,
  output logic [NUM_MASTERS-1:0]   m_grant,
  output logic [NUM_MASTERS-1:0]   m_yield,
  input  logic [24*NUM_MASTERS-1:0] m_address,
  input  logic [8*NUM_MASTERS-1:0] m_data_out,
  input  logic [NUM_MASTERS-1:0]   m_write,
  input  logic [NUM_MASTERS-1:0]   m_read,
  input  logic [2*NUM_MASTERS-1:0] m_bus_status,
  output logic                     cpu_bus_request,
  input  logic                     cpu_bus_ack,
  output logic                     bus_ack,
  output logic [23:0]              address_out,
  output logic [7:0]               data_out,
  output logic                     write,
  output logic                     read,
  output logic [1:0]               bus_status
);

  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_MASTERS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQUEST, S_GRANT, S_HANDOVER, S_RELEASE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   grant_idx_q, grant_idx_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;

  logic                   pick_found;
  logic [PW-1:0]          pick_idx;
  logic [NUM_MASTERS-1:0] holder_mask;
  logic                   holder_req;
  logic                   others_req;

  // Round-robin pick: first requester at or after rr_ptr; scanning downward lets the nearest win.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (m_request[(int'(rr_ptr_q) + k) % NUM_MASTERS]) begin
        pick_found = 1'b1;
        pick_idx   = PW'((int'(rr_ptr_q) + k) % NUM_MASTERS);
      end
    end
  end

  // Holder decode and whether anybody else is waiting behind it.
  always_comb begin
    holder_mask = '0;
    holder_mask[grant_idx_q] = 1'b1;
    holder_req = m_request[grant_idx_q];
    others_req = |(m_request & ~holder_mask);
  end

  // State register; reset wins over the clock enable so a reset always clears the bus at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      hold_cnt_q  <= '0;
    end else if (clk_ce) begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  // Next-state and outputs; all outputs derive from registered state so grant drops on the edge the release is seen.
  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    grant_idx_d     = grant_idx_q;
    hold_cnt_d      = hold_cnt_q;
    cpu_bus_request = 1'b0;
    bus_ack         = 1'b0;
    m_grant         = '0;
    m_yield         = '0;
    address_out     = '0;
    data_out        = '0;
    write           = 1'b0;
    read            = 1'b0;
    bus_status      = '0;
    case (state_q)
      S_IDLE: begin
        if (|m_request) state_d = S_REQUEST;
      end
      S_REQUEST: begin
        cpu_bus_request = 1'b1;
        if (cpu_bus_ack) begin
          if (pick_found) begin
            grant_idx_d = pick_idx;
            hold_cnt_d  = '0;
            state_d     = S_GRANT;
          end else begin
            state_d = S_RELEASE;
          end
        end
      end
      S_GRANT: begin
        cpu_bus_request = 1'b1;
        bus_ack         = 1'b1;
        m_grant         = holder_mask;
        address_out     = m_address[24*grant_idx_q +: 24];
        data_out        = m_data_out[8*grant_idx_q +: 8];
        write           = m_write[grant_idx_q];
        read            = m_read[grant_idx_q];
        bus_status      = m_bus_status[2*grant_idx_q +: 2];
        if (hold_cnt_q == HOLD_MAX) m_yield = holder_mask;
        if (!holder_req) begin
          rr_ptr_d = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + 1'b1;
          state_d  = others_req ? S_HANDOVER : S_RELEASE;
        end else if (others_req && hold_cnt_q != HOLD_MAX) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      S_HANDOVER: begin
        cpu_bus_request = 1'b1;
        if (pick_found) begin
          grant_idx_d = pick_idx;
          hold_cnt_d  = '0;
          state_d     = S_GRANT;
        end else begin
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!cpu_bus_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_master_arbiter.sv
// tb/tb_bus_master_arbiter.sv - directed vector bench for bus_master_arbiter
module tb_bus_master_arbiter;

  logic        clk = 1'b0;
  logic        clk_ce;
  logic        reset;
  logic [1:0]  m_request;
  logic [1:0]  m_grant;
  logic [1:0]  m_yield;
  logic [47:0] m_address;
  logic [15:0] m_data_out;
  logic [1:0]  m_write;
  logic [1:0]  m_read;
  logic [3:0]  m_bus_status;
  logic        cpu_bus_request;
  logic        cpu_bus_ack;
  logic        bus_ack;
  logic [23:0] address_out;
  logic [7:0]  data_out;
  logic        write;
  logic        read;
  logic [1:0]  bus_status;

  int n_cmp  = 0;
  int n_fail = 0;

  bus_master_arbiter #(.NUM_MASTERS(2), .MAX_HOLD(4)) dut (
    .clk(clk), .clk_ce(clk_ce), .reset(reset),
    .m_request(m_request), .m_grant(m_grant), .m_yield(m_yield),
    .m_address(m_address), .m_data_out(m_data_out),
    .m_write(m_write), .m_read(m_read), .m_bus_status(m_bus_status),
    .cpu_bus_request(cpu_bus_request), .cpu_bus_ack(cpu_bus_ack),
    .bus_ack(bus_ack), .address_out(address_out), .data_out(data_out),
    .write(write), .read(read), .bus_status(bus_status)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       ce;
    logic [1:0] req;
    logic       ack;
    logic [1:0] grant;
    logic [1:0] yield;
    logic       creq;
    logic       back;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  // Expected mux outputs follow from the expected grant and the fixed per-master bus values.
  task automatic chk_all(input string nm, input logic [1:0] eg, input logic [1:0] ey,
                         input logic ec, input logic eb);
    logic [23:0] ea;
    logic [7:0]  ed;
    logic        ew, er;
    logic [1:0]  es;
    ea = 24'h0; ed = 8'h0; ew = 1'b0; er = 1'b0; es = 2'b00;
    if (eg == 2'b01) begin
      ea = 24'h001234; ed = 8'hA5; ew = 1'b0; er = 1'b1; es = 2'b01;
    end else if (eg == 2'b10) begin
      ea = 24'hABCDEF; ed = 8'h5A; ew = 1'b1; er = 1'b0; es = 2'b11;
    end
    chk({nm, ".m_grant"}, 32'(m_grant), 32'(eg));
    chk({nm, ".m_yield"}, 32'(m_yield), 32'(ey));
    chk({nm, ".cpu_bus_request"}, 32'(cpu_bus_request), 32'(ec));
    chk({nm, ".bus_ack"}, 32'(bus_ack), 32'(eb));
    chk({nm, ".address_out"}, 32'(address_out), 32'(ea));
    chk({nm, ".data_out"}, 32'(data_out), 32'(ed));
    chk({nm, ".write"}, 32'(write), 32'(ew));
    chk({nm, ".read"}, 32'(read), 32'(er));
    chk({nm, ".bus_status"}, 32'(bus_status), 32'(es));
  endtask

  initial begin
    int n;
    m_address    = {24'hABCDEF, 24'h001234};
    m_data_out   = {8'h5A, 8'hA5};
    m_write      = 2'b10;
    m_read       = 2'b01;
    m_bus_status = {2'b11, 2'b01};
    reset = 1'b1; clk_ce = 1'b1; m_request = 2'b00; cpu_bus_ack = 1'b0;

    //               name                 rst   ce    req    ack   grant  yield  creq  back
    vecs.push_back('{"reset",             1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0});
    vecs.push_back('{"idle_to_req",       1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0});
    vecs.push_back('{"req_wait1",         1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0});
    vecs.push_back('{"req_wait2",         1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0});
    vecs.push_back('{"ack_grant0",        1'b0, 1'b1, 2'b01, 1'b1, 2'b01, 2'b00, 1'b1, 1'b1});
    vecs.push_back('{"hold1",             1'b0, 1'b1, 2'b11, 1'b1, 2'b01, 2'b00, 1'b1, 1'b1});
    vecs.push_back('{"hold2",             1'b0, 1'b1, 2'b11, 1'b1, 2'b01, 2'b00, 1'b1, 1'b1});
    vecs.push_back('{"hold3",             1'b0, 1'b1, 2'b11, 1'b1, 2'b01, 2'b00, 1'b1, 1'b1});
    vecs.push_back('{"hold4_yield",       1'b0, 1'b1, 2'b11, 1'b1, 2'b01, 2'b01, 1'b1, 1'b1});
    vecs.push_back('{"hold_saturated",    1'b0, 1'b1, 2'b11, 1'b1, 2'b01, 2'b01, 1'b1, 1'b1});
    vecs.push_back('{"drop0_handover",    1'b0, 1'b1, 2'b10, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0});
    vecs.push_back('{"grant1",            1'b0, 1'b1, 2'b10, 1'b1, 2'b10, 2'b00, 1'b1, 1'b1});
    vecs.push_back('{"g1_hold",           1'b0, 1'b1, 2'b11, 1'b1, 2'b10, 2'b00, 1'b1, 1'b1});
    vecs.push_back('{"drop1_handover",    1'b0, 1'b1, 2'b01, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0});
    vecs.push_back('{"rr_wrap_grant0",    1'b0, 1'b1, 2'b11, 1'b1, 2'b01, 2'b00, 1'b1, 1'b1});
    vecs.push_back('{"drop0_handover2",   1'b0, 1'b1, 2'b10, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0});
    vecs.push_back('{"grant1_again",      1'b0, 1'b1, 2'b11, 1'b1, 2'b10, 2'b00, 1'b1, 1'b1});
    vecs.push_back('{"ce_low_freeze",     1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 2'b00, 1'b1, 1'b1});
    vecs.push_back('{"last_drop_release", 1'b0, 1'b1, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0});
    vecs.push_back('{"release_ign_req",   1'b0, 1'b1, 2'b01, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0});
    vecs.push_back('{"release_hold",      1'b0, 1'b1, 2'b01, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0});
    vecs.push_back('{"release_to_idle",   1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0});
    vecs.push_back('{"idle_to_req2",      1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0});
    vecs.push_back('{"grant0_again",      1'b0, 1'b1, 2'b01, 1'b1, 2'b01, 2'b00, 1'b1, 1'b1});
    vecs.push_back('{"drop_release",      1'b0, 1'b1, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0});
    vecs.push_back('{"to_idle",           1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0});
    vecs.push_back('{"req_again",         1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0});
    vecs.push_back('{"req_dropped",       1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0});
    vecs.push_back('{"ack_no_req",        1'b0, 1'b1, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0});
    vecs.push_back('{"release_idle",      1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; clk_ce = vecs[i].ce;
      m_request = vecs[i].req; cpu_bus_ack = vecs[i].ack;
      tick();
      chk_all(vecs[i].name, vecs[i].grant, vecs[i].yield, vecs[i].creq, vecs[i].back);
    end

    // Yield timing: rr_ptr is 1 here, master 0 alone requests and wins, then master 1 waits.
    m_request = 2'b01; cpu_bus_ack = 1'b1;
    tick();
    tick();
    chk_all("y_grant0", 2'b01, 2'b00, 1'b1, 1'b1);
    m_request = 2'b11;
    n = 0;
    while (n < 20) begin
      tick();
      n++;
      if (m_yield[0]) break;
    end
    chk("y_wait_cycles", 32'(n), 32'd4);
    tick();
    chk_all("y_stays", 2'b01, 2'b01, 1'b1, 1'b1);
    m_request = 2'b10;
    tick();
    chk_all("y_clear_on_drop", 2'b00, 2'b00, 1'b1, 1'b0);
    tick();
    chk_all("y_grant1", 2'b10, 2'b00, 1'b1, 1'b1);

    // Reset during GRANT with the clock enable low still clears everything on that edge.
    reset = 1'b1; clk_ce = 1'b0; m_request = 2'b11;
    tick();
    chk_all("rst_ce_low", 2'b00, 2'b00, 1'b0, 1'b0);
    reset = 1'b0; clk_ce = 1'b1; m_request = 2'b00; cpu_bus_ack = 1'b0;
    tick();
    chk_all("post_rst_idle", 2'b00, 2'b00, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
